// File: rtl/sgpr_pkg.sv
// sgpr_pkg: shared state encoding and register-file geometry for the sgpr copy controller
package sgpr_pkg;

   typedef enum logic [1:0] {IDLE, COPY, DONE} sgpr_copy_state_e;

   localparam int REG_ADDR_W = 5;

   function automatic int addr_width(input bit rv32e);
      return rv32e ? 4 : 5;
   endfunction

   function automatic int num_words(input bit rv32e);
      return 1 << addr_width(rv32e);
   endfunction

endpackage

// File: rtl/sgpr_copy_ctrl.sv
// sgpr_copy_ctrl: owns the sgpr write port; forwards core writes or copies x1..xN-1 from the golden file
module sgpr_copy_ctrl
   import sgpr_pkg::*;
#(
   parameter bit RV32E      = 1'b0,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  drop_err_o,
   input  logic [REG_ADDR_W-1:0] core_waddr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   input  logic                  core_we_i,
   output logic                  core_gnt_o,
   output logic [REG_ADDR_W-1:0] src_raddr_o,
   input  logic [DATA_WIDTH-1:0] src_rdata_i,
   output logic [REG_ADDR_W-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  rf_we_o
);

   localparam int            AW   = addr_width(RV32E);
   localparam logic [AW-1:0] LAST = AW'(num_words(RV32E) - 1);

   sgpr_copy_state_e state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             drop_err_q, drop_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= AW'(1);
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         drop_err_q <= drop_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      drop_err_d  = drop_err_q;
      done_o      = 1'b0;
      src_raddr_o = '0;
      rf_waddr_o  = core_waddr_i;
      rf_wdata_o  = core_wdata_i;
      rf_we_o     = 1'b0;
      case (state_q)
         IDLE: begin
            rf_we_o = core_we_i;
            if (start_i) begin
               state_d    = COPY;
               idx_d      = AW'(1);
               drop_err_d = 1'b0;
            end
         end
         COPY: begin
            // idx starts at 1, so x0 is never a copy target
            src_raddr_o = REG_ADDR_W'(idx_q);
            rf_waddr_o  = REG_ADDR_W'(idx_q);
            rf_wdata_o  = src_rdata_i;
            rf_we_o     = 1'b1;
            idx_d       = (idx_q == LAST) ? AW'(1) : idx_q + 1'b1;
            state_d     = (idx_q == LAST) ? DONE : COPY;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && core_we_i) drop_err_d = 1'b1;
   end

   assign busy_o     = state_q != IDLE;
   assign core_gnt_o = !busy_o;
   assign drop_err_o = drop_err_q;

endmodule

// File: tb/tb_sgpr_copy_ctrl.sv
// tb_sgpr_copy_ctrl: directed checks of pass-through, full/RV32E copies, dropped writes and reset abort
module tb_sgpr_copy_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start_e = 1'b0;
   logic        core_we = 1'b0;
   logic [4:0]  core_waddr = '0;
   logic [31:0] core_wdata = '0;

   logic        busy, done, drop_err, gnt, rf_we;
   logic [4:0]  src_raddr, rf_waddr;
   logic [31:0] src_rdata, rf_wdata;
   logic        busy_e, done_e, drop_err_e, gnt_e, rf_we_e;
   logic [4:0]  src_raddr_e, rf_waddr_e;
   logic [31:0] src_rdata_e, rf_wdata_e;

   logic [31:0] mem [32];
   logic        hi_wr_e;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   assign src_rdata   = 32'h1000 + 32'(src_raddr);
   assign src_rdata_e = 32'h1000 + 32'(src_raddr_e);

   sgpr_copy_ctrl #(.RV32E(1'b0), .DATA_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .drop_err_o(drop_err), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
      .core_we_i(core_we), .core_gnt_o(gnt), .src_raddr_o(src_raddr), .src_rdata_i(src_rdata),
      .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we)
   );

   sgpr_copy_ctrl #(.RV32E(1'b1), .DATA_WIDTH(32)) u_dut_e (
      .clk(clk), .rst_n(rst_n), .start_i(start_e), .busy_o(busy_e), .done_o(done_e),
      .drop_err_o(drop_err_e), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
      .core_we_i(core_we), .core_gnt_o(gnt_e), .src_raddr_o(src_raddr_e), .src_rdata_i(src_rdata_e),
      .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e), .rf_we_o(rf_we_e)
   );

   // simple sgpr model sharing rst_n
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         hi_wr_e <= 1'b0;
      end else begin
         if (rf_we) mem[rf_waddr] <= rf_wdata;
         if (rf_we_e && rf_waddr_e[4]) hi_wr_e <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dones, writes;
      #2;
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst drop", 32'(drop_err), 0);
      check("rst rf_we", 32'(rf_we), 0);
      check("rst src_raddr", 32'(src_raddr), 0);
      check("rst gnt", 32'(gnt), 1);
      check("rst busy_e", 32'(busy_e), 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEADBEEF;
      #1;
      check("idle rf_we", 32'(rf_we), 1);
      check("idle rf_waddr", 32'(rf_waddr), 5);
      check("idle rf_wdata", rf_wdata, 32'hDEADBEEF);
      check("idle gnt", 32'(gnt), 1);
      step();
      core_we = 1'b0;
      check("idle x5", mem[5], 32'hDEADBEEF);

      start = 1'b1;
      for (int c = 0; c <= 33; c++) begin
         @(negedge clk);
         check($sformatf("copy busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 32));
         check($sformatf("copy done c%0d", c), 32'(done), 32'(c == 32));
         check($sformatf("copy we c%0d", c), 32'(rf_we), 32'(c >= 1 && c <= 31));
         if (c >= 1 && c <= 31) begin
            check($sformatf("copy waddr c%0d", c), 32'(rf_waddr), c);
            check($sformatf("copy wdata c%0d", c), rf_wdata, 32'h1000 + c);
            check($sformatf("copy raddr c%0d", c), 32'(src_raddr), c);
         end
         step();
         start = 1'b0;
      end
      check("copy x0", mem[0], 0);
      check("copy x1", mem[1], 32'h1001);
      check("copy x31", mem[31], 32'h101F);

      start_e = 1'b1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         check($sformatf("e busy c%0d", c), 32'(busy_e), 32'(c >= 1 && c <= 16));
         check($sformatf("e done c%0d", c), 32'(done_e), 32'(c == 16));
         check($sformatf("e we c%0d", c), 32'(rf_we_e), 32'(c >= 1 && c <= 15));
         if (c >= 1 && c <= 15) begin
            check($sformatf("e waddr c%0d", c), 32'(rf_waddr_e), c);
            check($sformatf("e wdata c%0d", c), rf_wdata_e, 32'h1000 + c);
         end
         step();
         start_e = 1'b0;
      end
      check("e no hi write", 32'(hi_wr_e), 0);

      start = 1'b1; core_waddr = 5'd3; core_wdata = 32'h0BAD;
      for (int c = 0; c <= 35; c++) begin
         @(negedge clk);
         if (c == 10) begin
            check("drop gnt", 32'(gnt), 0);
            check("drop waddr", 32'(rf_waddr), 10);
            check("drop wdata", rf_wdata, 32'h100A);
            check("drop pre", 32'(drop_err), 0);
         end
         if (c == 11) check("drop set", 32'(drop_err), 1);
         if (c == 35) begin
            check("drop sticky", 32'(drop_err), 1);
            check("drop idle", 32'(busy), 0);
         end
         step();
         start = 1'b0;
         core_we = (c == 9);
      end
      check("drop x3", mem[3], 32'h1003);

      start = 1'b1; core_we = 1'b1; core_waddr = 5'd7; core_wdata = 32'h77;
      dones = 0;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("sim we", 32'(rf_we), 1);
            check("sim waddr", 32'(rf_waddr), 7);
            check("sim gnt", 32'(gnt), 1);
         end
         if (c == 1) begin
            check("sim drop clr", 32'(drop_err), 0);
            check("sim x7 first", mem[7], 32'h77);
         end
         if (c == 33) check("sim no requeue", 32'(busy), 0);
         if (done) check("sim done cyc", c, 32);
         dones += int'(done);
         step();
         start = (c == 4);
         core_we = 1'b0;
      end
      check("sim done count", dones, 1);

      start = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         start = 1'b0;
      end
      check("rmid busy pre", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("rmid rf_we", 32'(rf_we), 0);
      check("rmid busy", 32'(busy), 0);
      check("rmid raddr", 32'(src_raddr), 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("rmid idle", 32'(busy), 0);
      start = 1'b1;
      writes = 0;
      for (int c = 0; c <= 33; c++) begin
         @(negedge clk);
         writes += int'(rf_we);
         if (done) check("rmid done cyc", c, 32);
         step();
         start = 1'b0;
      end
      check("rmid writes", writes, 31);
      check("rmid x31", mem[31], 32'h101F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sgpr_copy_ctrl.md
Name: sgpr_copy_ctrl

Overview:
- Controller in front of the sgpr single write port.
- In normal mode it passes the core's register writes straight through.
- On a recovery request it takes over the write port and copies every architectural register (x1..xN-1) from a golden source register file into the sgpr, one register per cycle, then hands the port back to the core.
- Sits between the core/recovery FSM and sgpr in the fault-tolerant system.

Parameters:
- RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4); 0 selects 32 registers (ADDR_WIDTH=5).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  copy request; sampled only in IDLE
- busy_o  output  1  high whenever state != IDLE
- done_o  output  1  one-cycle pulse, copy finished
- drop_err_o  output  1  sticky: core write dropped while busy
- core_waddr_i  input  5  core write address
- core_wdata_i  input  DATA_WIDTH  core write data
- core_we_i  input  1  core write enable
- core_gnt_o  output  1  core write accepted this cycle (= !busy_o)
- src_raddr_o  output  5  golden register file read address
- src_rdata_i  input  DATA_WIDTH  golden read data, combinational, same cycle
- rf_waddr_o  output  5  to sgpr waddr_a_i
- rf_wdata_o  output  DATA_WIDTH  to sgpr wdata_a_i
- rf_we_o  output  1  to sgpr we_a_i

Behaviour:
- Reset is decided: rst_n asynchronous, active-low; clock is clk.
- Reset values:
  - State IDLE; index counter = 1.
  - busy_o=0, done_o=0, drop_err_o=0, rf_we_o=0, src_raddr_o=0.
- States: IDLE, COPY, DONE.
- IDLE:
  - rf_* = core_* combinationally; core_gnt_o=1.
  - src_raddr_o=0.
  - start_i=1 → COPY next cycle with idx=1.
  - start_i and core_we_i asserted in the same IDLE cycle: the core write is performed that cycle, and the copy starts next cycle.
- COPY:
  - src_raddr_o = idx, zero-extended to 5 bits.
  - rf_waddr_o = idx, rf_wdata_o = src_rdata_i, rf_we_o = 1.
  - idx increments each cycle.
  - When idx = NUM_WORDS-1, go to DONE and reset idx to 1.
  - Register 0 is never written.
  - COPY lasts exactly NUM_WORDS-1 cycles: 31, or 15 when RV32E=1.
- DONE:
  - One cycle; done_o=1, rf_we_o=0, busy_o=1.
  - Next state IDLE.
- start_i while in COPY or DONE is ignored; it is not queued.
- Core writes while busy_o=1:
  - core_gnt_o=0 and the write is not forwarded.
  - If core_we_i=1, drop_err_o is set.
  - drop_err_o clears only on an accepted start_i or on reset.
- Address width: with RV32E=1, core_waddr_i[4] is passed through unchanged (sgpr ignores it); copy addresses have bit 4 = 0.
- Reset mid-COPY:
  - Immediate return to IDLE, rf_we_o=0.
  - Registers already copied keep their new values; sgpr resets anyway if it shares rst_n.
- Latency from start_i to done_o:
  - NUM_WORDS cycles: start_i at cycle 0, first copy write at cycle 1, done_o at cycle NUM_WORDS.
  - With the default RV32E=0 that is done_o at cycle 32.
- The only registered state is state, idx and drop_err_o; all port outputs are combinational from these plus inputs.

Decomposition:
- sgpr_pkg holds:
  - state enum sgpr_copy_state_e {IDLE, COPY, DONE}
  - localparam function for ADDR_WIDTH / NUM_WORDS from RV32E
  - REG_ADDR_W = 5
- No sub-module: the write-port mux is inline.
- The top level instantiates sgpr_copy_ctrl with sgpr.

Test Plan:
- Idle pass-through: core_we_i=1, addr=5, data=0xDEADBEEF → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, core_gnt_o=1 the same cycle; sgpr x5 reads back 0xDEADBEEF.
- Full copy (RV32E=0): source xi = 0x1000+i; pulse start_i at cycle 0 → rf writes for addr 1..31 in cycles 1..31, done_o at cycle 32 only, busy_o cycles 1..32; sgpr x0=0, x31=0x101F.
- RV32E=1 copy: same stimulus → 15 writes for addr 1..15, done_o at cycle 16, no write to addr ≥16.
- Core write during copy: core_we_i=1 at cycle 10 → core_gnt_o=0, write not forwarded, drop_err_o=1 from cycle 11 until the next accepted start_i clears it.
- Simultaneous start and core write in IDLE, plus start during COPY: the IDLE core write lands first; a second start_i at cycle 5 is ignored; done_o pulses exactly once at cycle 32.
- Reset mid-copy: assert rst_n=0 at cycle 12 → rf_we_o=0 and busy_o=0 immediately; after release the block is in IDLE, and a fresh start_i produces a full 31-write copy.
